// File: rtl/paddle_axis.sv
// Frame-rate paddle controller for one Pong player: synchronised, debounced buttons drive a
// clamped, accelerating paddle along one axis; extents and pixel colour are exported.
module paddle_axis #(
  parameter int          HRES       = 1280,
  parameter int          VRES       = 720,
  parameter int          AXIS       = 0,
  parameter int          LEN        = 200,
  parameter int          THICK      = 20,
  parameter int          CROSS_POS  = 700,
  parameter int          INIT_POS   = 540,
  parameter int          VEL_MIN    = 4,
  parameter int          VEL_MAX    = 16,
  parameter int          ACCEL      = 2,
  parameter int          DEB_CYCLES = 16,
  parameter logic [23:0] COLOR      = 24'hEFE62E
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               fsync,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  input  logic               btn_neg,
  input  logic               btn_pos,
  output logic [23:0]        pixel,
  output logic               active,
  output logic signed [11:0] pos_lo,
  output logic signed [11:0] pos_hi,
  output logic [1:0]         dir
);

  localparam int ResAx  = (AXIS == 0) ? HRES : VRES;
  localparam int PosMax = ResAx - LEN;
  localparam int CntW   = $clog2(DEB_CYCLES + 1);

  localparam logic signed [12:0] PosMaxS = 13'(PosMax);
  localparam logic signed [11:0] CrossLo = 12'(CROSS_POS);
  localparam logic signed [11:0] CrossHi = 12'(CROSS_POS + THICK - 1);

  if (VEL_MIN > VEL_MAX) begin : g_err_vel
    $error("paddle_axis: VEL_MIN exceeds VEL_MAX");
  end
  if (LEN > ResAx) begin : g_err_len
    $error("paddle_axis: LEN exceeds axis resolution");
  end
  if (INIT_POS < 0 || INIT_POS > PosMax) begin : g_err_init
    $error("paddle_axis: INIT_POS out of range");
  end
  if (DEB_CYCLES < 1) begin : g_err_deb
    $error("paddle_axis: DEB_CYCLES must be at least 1");
  end

  // Index 0 is the neg button, index 1 the pos button.
  logic [1:0]        sync1_q, sync2_q;
  logic [1:0]        deb_q, deb_d;
  logic [1:0]        req_q, req_d;
  logic [1:0]        eff;
  logic [CntW-1:0]   cnt_q [2];
  logic [CntW-1:0]   cnt_d [2];

  logic signed [11:0] pos_q, pos_d;
  logic [1:0]         dir_q, dir_d, mv_dir;
  logic [11:0]        spd_q, spd_d, spd_new;
  logic [12:0]        spd_sum;
  logic signed [12:0] pos_ext, spd_ext, pos_mv;

  always_comb begin : p_debounce
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntW'(DEB_CYCLES)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // A tap that debounces and releases within one frame still counts via the sticky flag.
  assign eff   = req_q | deb_q;
  assign req_d = fsync ? 2'b00 : eff;

  always_comb begin : p_move
    pos_d   = pos_q;
    dir_d   = dir_q;
    spd_d   = spd_q;
    mv_dir  = eff[1] ? 2'b10 : 2'b01;
    spd_sum = {1'b0, spd_q} + 13'(ACCEL);
    if (dir_q != mv_dir) begin
      spd_new = 12'(VEL_MIN);
    end else if (spd_sum > 13'(VEL_MAX)) begin
      spd_new = 12'(VEL_MAX);
    end else begin
      spd_new = spd_sum[11:0];
    end
    pos_ext = $signed({pos_q[11], pos_q});
    spd_ext = $signed({1'b0, spd_new});
    pos_mv  = eff[1] ? (pos_ext + spd_ext) : (pos_ext - spd_ext);
    if (fsync) begin
      if (eff[0] ^ eff[1]) begin
        dir_d = mv_dir;
        spd_d = spd_new;
        if (pos_mv < 13'sd0) begin
          pos_d = '0;
        end else if (pos_mv > PosMaxS) begin
          pos_d = PosMaxS[11:0];
        end else begin
          pos_d = pos_mv[11:0];
        end
      end else begin
        dir_d = 2'b00;
        spd_d = 12'(VEL_MIN);
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '{default: '0};
      req_q   <= '0;
      pos_q   <= 12'(INIT_POS);
      dir_q   <= 2'b00;
      spd_q   <= 12'(VEL_MIN);
    end else begin
      sync1_q <= {btn_pos, btn_neg};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      spd_q   <= spd_d;
    end
  end

  logic signed [11:0] along, across;

  assign along  = (AXIS == 0) ? hpos : vpos;
  assign across = (AXIS == 0) ? vpos : hpos;
  assign pos_lo = pos_q;
  assign pos_hi = pos_q + $signed(12'(LEN - 1));
  assign dir    = dir_q;
  assign active = (along >= pos_q) && (along <= pos_hi) &&
                  (across >= CrossLo) && (across <= CrossHi);
  assign pixel  = active ? COLOR : 24'h0;

endmodule

// File: tb/tb_paddle_axis.sv
// Scoreboard bench for paddle_axis: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares them against a horizontal and a vertical instance.
module tb_paddle_axis;

  typedef struct {
    int id;
    int kind;
    int pos;
    int hi;
    int dir;
    int act;
    int pix;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fsync = 1'b0;
  logic signed [11:0] hpos = '0;
  logic signed [11:0] vpos = '0;
  logic               btn_neg = 1'b0;
  logic               btn_pos = 1'b0;

  logic [23:0]        pix_h, pix_v;
  logic               act_h, act_v;
  logic signed [11:0] pos_lo_h, pos_hi_h, pos_lo_v, pos_hi_v;
  logic [1:0]         dir_h, dir_v;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_id   = 0;

  always #5 clk = ~clk;

  paddle_axis u_h (
    .pixel_clk(clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
    .btn_neg(btn_neg), .btn_pos(btn_pos), .pixel(pix_h), .active(act_h),
    .pos_lo(pos_lo_h), .pos_hi(pos_hi_h), .dir(dir_h)
  );

  paddle_axis #(.AXIS(1), .CROSS_POS(20), .INIT_POS(300)) u_v (
    .pixel_clk(clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
    .btn_neg(1'b0), .btn_pos(1'b0), .pixel(pix_v), .active(act_v),
    .pos_lo(pos_lo_v), .pos_hi(pos_hi_v), .dir(dir_v)
  );

  task automatic cmp(input int id, input string what, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL check %0d %s: got %0d (0x%0h), expected %0d (0x%0h)",
               id, what, act, act, req, req);
    end
  endtask

  // Monitor: compares every pending expectation against what the DUT presents now.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        0: begin
          cmp(e.id, "h.pos_lo", int'(pos_lo_h), e.pos);
          cmp(e.id, "h.pos_hi", int'(pos_hi_h), e.hi);
          cmp(e.id, "h.dir", int'(dir_h), e.dir);
        end
        1: begin
          cmp(e.id, "h.active", int'(act_h), e.act);
          cmp(e.id, "h.pixel", int'(pix_h), e.pix);
        end
        2: begin
          cmp(e.id, "v.active", int'(act_v), e.act);
          cmp(e.id, "v.pixel", int'(pix_v), e.pix);
        end
        default: begin
          cmp(e.id, "v.pos_lo", int'(pos_lo_v), e.pos);
          cmp(e.id, "v.pos_hi", int'(pos_hi_v), e.hi);
          cmp(e.id, "v.dir", int'(dir_v), e.dir);
        end
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    fsync = 1'b1;
    step(1);
    fsync = 1'b0;
  endtask

  task automatic chk_state(input int kind, input int p, input int d);
    exp_q.push_back('{n_id, kind, p, p + 199, d, 0, 0});
    n_id++;
    step(1);
  endtask

  task automatic chk_pix(input int kind, input int h, input int v, input int a);
    hpos = 12'(h);
    vpos = 12'(v);
    exp_q.push_back('{n_id, kind, 0, 0, 0, a, a ? 24'hEFE62E : 0});
    n_id++;
    step(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ramp[4] = '{568, 580, 594, 610};
    int p;
    step(3);
    rst = 1'b0;

    chk_state(0, 540, 0);
    chk_state(3, 300, 0);
    chk_pix(1, 540, 700, 1);
    chk_pix(1, 739, 719, 1);
    chk_pix(1, 740, 700, 0);
    chk_pix(1, 540, 699, 0);
    chk_pix(1, 539, 710, 0);
    chk_pix(1, 600, 720, 0);
    chk_pix(1, -5, 700, 0);
    chk_pix(2, 20, 300, 1);
    chk_pix(2, 39, 499, 1);
    chk_pix(2, 40, 300, 0);
    chk_pix(2, 20, 500, 0);
    hpos = '0;
    vpos = '0;

    frame();
    chk_state(0, 540, 0);

    // Hold pos: ramp 4, 6, 8, ... up to the 16 ceiling, then clamp at 1080.
    btn_pos = 1'b1;
    step(30); frame(); chk_state(0, 544, 2);
    step(20); frame(); chk_state(0, 550, 2);
    step(20); frame(); chk_state(0, 558, 2);
    foreach (ramp[i]) begin
      step(20); frame(); chk_state(0, ramp[i], 2);
    end
    p = 610;
    while (p < 1080) begin
      p = (p + 16 > 1080) ? 1080 : p + 16;
      step(20); frame(); chk_state(0, p, 2);
    end

    // Latched pos after release: clamped move keeps dir.
    btn_pos = 1'b0;
    step(30); frame(); chk_state(0, 1080, 2);
    // Reversal restarts at VEL_MIN.
    btn_neg = 1'b1;
    step(30); frame(); chk_state(0, 1076, 1);
    step(20); frame(); chk_state(0, 1070, 1);
    btn_neg = 1'b0;
    step(30); frame(); chk_state(0, 1062, 1);
    step(20); frame(); chk_state(0, 1062, 0);

    // Glitch shorter than the debounce window is ignored.
    btn_pos = 1'b1; step(10); btn_pos = 1'b0;
    step(40); frame(); chk_state(0, 1062, 0);
    // 40-cycle tap fully inside a frame moves once.
    btn_pos = 1'b1; step(40); btn_pos = 1'b0;
    step(30); frame(); chk_state(0, 1066, 2);
    step(20); frame(); chk_state(0, 1066, 0);

    // Both buttons: still.
    btn_neg = 1'b1;
    step(30); frame(); chk_state(0, 1062, 1);
    step(20); frame(); chk_state(0, 1056, 1);
    btn_pos = 1'b1;
    step(30); frame(); chk_state(0, 1056, 0);
    // Back-to-back fsync: first sees latched neg (still), second only current pos.
    btn_neg = 1'b0;
    step(30);
    fsync = 1'b1; step(2); fsync = 1'b0;
    chk_state(0, 1060, 2);
    step(20); frame(); chk_state(0, 1066, 2);
    step(20); frame(); chk_state(0, 1074, 2);

    // Reset mid-move with pos held.
    step(5);
    rst = 1'b1; step(1); rst = 1'b0;
    chk_state(0, 540, 0);
    step(30); chk_state(0, 540, 0);
    frame(); chk_state(0, 544, 2);

    // fsync coinciding with reset is ignored.
    step(5);
    rst = 1'b1; fsync = 1'b1; step(1); rst = 1'b0; fsync = 1'b0;
    chk_state(0, 540, 0);
    step(30); frame(); chk_state(0, 544, 2);
    btn_pos = 1'b0;

    step(5);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_axis.md
# paddle_axis

Parametrised next-generation paddle controller for the Pong datapath: one instance per player. It moves a rectangular paddle along a selectable axis (horizontal or vertical) at frame rate, with synchronised and debounced buttons, per-frame press latching and speed ramping while a button is held. It sits between the board buttons and the pixel mixer, and exports its extents for the ball-collision logic.

## Interface

- HRES, 1280, active horizontal resolution (pixels)
- VRES, 720, active vertical resolution (lines)
- AXIS, 0, movement axis: 0 = horizontal (buttons move along hpos), 1 = vertical (along vpos)
- LEN, 200, paddle extent along the movement axis
- THICK, 20, paddle extent across the movement axis
- CROSS_POS, 700, fixed low coordinate on the cross axis (vpos if AXIS=0, hpos if AXIS=1)
- INIT_POS, 540, low-edge position along the movement axis after reset
- VEL_MIN, 4, speed of the first frame of a move (pixels/frame)
- VEL_MAX, 16, speed ceiling
- ACCEL, 2, speed increment per consecutive same-direction frame
- DEB_CYCLES, 16, debounce stability window in pixel_clk cycles (≥1)
- COLOR, 24'hEFE62E, RGB888 paddle colour

Ports:
- pixel_clk  in  1  pixel clock; all state on rising edge
- rst  in  1  reset rst, synchronous, active-high; clock pixel_clk
- fsync  in  1  one-cycle pulse, once per frame
- hpos  in  12 signed  current pixel column
- vpos  in  12 signed  current pixel row
- btn_neg  in  1  asynchronous button, move toward lower coordinate
- btn_pos  in  1  asynchronous button, move toward higher coordinate
- pixel  out  24  {R,G,B}; COLOR when active, else 0
- active  out  1  current (hpos,vpos) lies inside paddle
- pos_lo  out  12 signed  low edge along movement axis
- pos_hi  out  12 signed  pos_lo + LEN − 1
- dir  out  2  last applied move: 2'b00 still, 2'b01 neg, 2'b10 pos

## Operation

- Elaboration: error if VEL_MIN > VEL_MAX, LEN > axis resolution, INIT_POS outside 0..RES_AX−LEN, or DEB_CYCLES < 1 (RES_AX = HRES if AXIS=0, else VRES).
- Button path per input: 2-flop synchroniser → debouncer. The debouncer holds level deb. A counter increments each cycle while the synchronised value ≠ deb and clears when they are equal. When the count reaches DEB_CYCLES, deb takes the synchronised value and the counter clears.
- Latching: sticky flags req_neg/req_pos are set on any cycle the matching deb is high and cleared on every fsync cycle. Effective request on the fsync cycle = flag OR current deb, so a tap that debounces and releases within one frame still moves the paddle once.
- Decision on the fsync cycle:
  - exactly one effective request → move in that direction;
  - both or neither → still.
- Speed register spd:
  - still → spd=VEL_MIN, dir=00, no position change;
  - move in the same direction as the current dir → spd_new = min(spd+ACCEL, VEL_MAX);
  - any other move (from still or reversal) → spd_new = VEL_MIN.
  - The move uses spd_new, then stores it.
- Position: computed in 13-bit signed; pos_lo ± spd_new clamped to [0, RES_AX−LEN]. A clamped move still updates dir and spd.
- Geometry (combinational from registered pos_lo):
  - AXIS=0: columns pos_lo..pos_hi, rows CROSS_POS..CROSS_POS+THICK−1;
  - AXIS=1: axes swapped.
  - active requires both inclusive compares to pass; pixel is gated by active.

## Timing

- Reset: pos_lo=INIT_POS, pos_hi=INIT_POS+LEN−1, dir=00, spd=VEL_MIN, flags 0, deb 0, counters 0, sync flops 0. active and pixel follow combinationally from the reset position.
- Button latency: a level held from sampling edge k reaches deb at edge k+2+DEB_CYCLES. Glitches shorter than DEB_CYCLES synchronised cycles are ignored.
- Position, dir and spd update only on the edge where fsync=1 and take effect on the next cycle. They are stable for the rest of the frame.
- active/pixel have zero latency from hpos/vpos.
- Reset mid-frame or mid-move overrides everything on that edge. fsync together with rst is ignored.
- fsync on consecutive cycles: each is evaluated independently. Flags were cleared by the first, so only the current deb counts for the second.

## Test plan

- Defaults, hold btn_pos for 3 frames after debounce → pos_lo 544, 550, 558; dir=10; speed 4, 6, 8.
- Hold btn_pos from pos_lo=1070 with spd at 16 → pos_lo=1080, pos_hi=1279, no overshoot. Then hold btn_neg → pos_lo=1076 (spd resets to 4 on reversal).
- btn_pos pulse of 10 cycles (< DEB_CYCLES=16) → no move, dir=00. A 40-cycle pulse fully between two fsyncs → exactly one 4-pixel move.
- Both buttons held across fsync → pos unchanged, dir=00, spd back to 4. Next frame with btn_pos only → +4.
- Pixel check at pos_lo=540, AXIS=0:
  - (hpos,vpos)=(540,700) → active=1, pixel=EFE62E;
  - (739,719) → 1; (740,700) → 0; (540,699) → 0.
  - AXIS=1 instance with CROSS_POS=20: (20,INIT_POS) → active=1.
- rst asserted mid-move at pos_lo=800 while btn_pos held → next cycle pos_lo=540, dir=00. After release of rst, movement resumes at speed 4 only after the next fsync.
